// File: rtl/bottling_plant_sim.sv
// rtl/bottling_plant_sim.sv - pill bottling line: hopper, timed pill dispenser and bottle conveyor
module bottling_plant_sim #(
  parameter int PILL_PERIOD   = 100,
  parameter int MOVE_CYCLES   = 2000,
  parameter int HOPPER_CAP    = 999,
  parameter int REFILL_AMOUNT = 100
) (
  input  logic       clk_1khz,
  input  logic       switch_clr,
  input  logic       fill_en,
  input  logic       bottle_advance,
  input  logic       hopper_refill,
  input  logic       fault_hopper,
  input  logic       fault_jam,
  output logic       pill_pulse,
  output logic       bottle_ready,
  output logic       conveyor_moving,
  output logic       hopper_empty,
  output logic [9:0] hopper_level,
  output logic [9:0] pills_in_bottle,
  output logic [6:0] bottles_done,
  output logic       jammed
);

  typedef enum logic [1:0] {IDLE, FILLING, MOVING, JAMMED} state_t;

  localparam logic [9:0]  PILL_RELOAD = 10'(PILL_PERIOD - 1);
  localparam logic [11:0] MOVE_RELOAD = 12'(MOVE_CYCLES - 1);
  localparam logic [10:0] CAP_W       = 11'(HOPPER_CAP);
  localparam logic [9:0]  CAP_LEVEL   = 10'(HOPPER_CAP);
  localparam logic [10:0] REFILL_W    = 11'(REFILL_AMOUNT);
  localparam logic [9:0]  PILLS_MAX   = 10'd1023;
  localparam logic [6:0]  DONE_LAST   = 7'd99;

  state_t      state, state_nxt;
  logic [9:0]  pill_timer, pill_timer_nxt;
  logic [11:0] move_timer, move_timer_nxt;
  logic        pill_drop;
  logic [10:0] level_sum;
  logic [9:0]  level_nxt;
  logic [9:0]  pills_nxt;
  logic [6:0]  done_nxt;
  logic        ready_nxt;
  logic        moving_nxt;
  logic        jammed_nxt;

  // The only unregistered output: a hopper fault must block dispensing immediately.
  assign hopper_empty = (hopper_level == 10'd0) | fault_hopper;

  always_ff @(posedge clk_1khz) begin
    if (switch_clr) begin
      state           <= IDLE;
      pill_timer      <= 10'd0;
      move_timer      <= 12'd0;
      pill_pulse      <= 1'b0;
      bottle_ready    <= 1'b1;
      conveyor_moving <= 1'b0;
      jammed          <= 1'b0;
      hopper_level    <= CAP_LEVEL;
      pills_in_bottle <= 10'd0;
      bottles_done    <= 7'd0;
    end else begin
      state           <= state_nxt;
      pill_timer      <= pill_timer_nxt;
      move_timer      <= move_timer_nxt;
      pill_pulse      <= pill_drop;
      bottle_ready    <= ready_nxt;
      conveyor_moving <= moving_nxt;
      jammed          <= jammed_nxt;
      hopper_level    <= level_nxt;
      pills_in_bottle <= pills_nxt;
      bottles_done    <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (bottle_advance) begin
          state_nxt = MOVING;
        end else if (fill_en && !hopper_empty) begin
          state_nxt = FILLING;
        end
      end
      FILLING: begin
        if (bottle_advance) begin
          state_nxt = MOVING;
        end else if (!fill_en) begin
          state_nxt = IDLE;
        end
      end
      MOVING: begin
        if (fault_jam) begin
          state_nxt = JAMMED;
        end else if (move_timer == 12'd0) begin
          state_nxt = IDLE;
        end
      end
      JAMMED: begin
        if (!fault_jam) begin
          state_nxt = MOVING;
        end
      end
    endcase
  end

  always_comb begin
    pill_drop      = 1'b0;
    pill_timer_nxt = pill_timer;
    move_timer_nxt = move_timer;
    pills_nxt      = pills_in_bottle;
    done_nxt       = bottles_done;
    case (state)
      IDLE: begin
        if (bottle_advance) begin
          move_timer_nxt = MOVE_RELOAD;
          pill_timer_nxt = 10'd0;
        end else if (fill_en && !hopper_empty) begin
          pill_timer_nxt = PILL_RELOAD;
        end
      end
      FILLING: begin
        if (bottle_advance) begin
          move_timer_nxt = MOVE_RELOAD;
          pill_timer_nxt = 10'd0;
        end else if (!fill_en) begin
          pill_timer_nxt = 10'd0;
        end else if (pill_timer == 10'd0) begin
          // An empty hopper still restarts the period so the next attempt keeps cadence.
          pill_timer_nxt = PILL_RELOAD;
          pill_drop      = !hopper_empty;
        end else begin
          pill_timer_nxt = pill_timer - 10'd1;
        end
      end
      MOVING: begin
        if (!fault_jam) begin
          if (move_timer == 12'd0) begin
            pills_nxt = 10'd0;
            done_nxt  = (bottles_done == DONE_LAST) ? 7'd0 : bottles_done + 7'd1;
          end else begin
            move_timer_nxt = move_timer - 12'd1;
          end
        end
      end
      JAMMED: begin
        move_timer_nxt = move_timer;
      end
    endcase

    if (pill_drop && (pills_in_bottle != PILLS_MAX)) begin
      pills_nxt = pills_in_bottle + 10'd1;
    end

    // A drop implies a non-empty hopper, so the subtraction cannot wrap.
    level_sum = {1'b0, hopper_level} - {10'd0, pill_drop} + (hopper_refill ? REFILL_W : 11'd0);
    level_nxt = (level_sum > CAP_W) ? CAP_LEVEL : level_sum[9:0];

    ready_nxt  = (state_nxt == IDLE) || (state_nxt == FILLING);
    moving_nxt = (state_nxt == MOVING);
    jammed_nxt = (state_nxt == JAMMED);
  end

endmodule

// File: tb/tb_bottling_plant_sim.sv
// tb/tb_bottling_plant_sim.sv - scoreboard bench for bottling_plant_sim with a cycle-level reference model
module tb_bottling_plant_sim;

  localparam int P   = 5;
  localparam int M   = 8;
  localparam int CAP = 40;
  localparam int R   = 15;

  localparam int S_IDLE = 0;
  localparam int S_FILL = 1;
  localparam int S_MOVE = 2;
  localparam int S_JAM  = 3;

  logic       clk_1khz = 1'b0;
  logic       switch_clr;
  logic       fill_en;
  logic       bottle_advance;
  logic       hopper_refill;
  logic       fault_hopper;
  logic       fault_jam;
  logic       pill_pulse;
  logic       bottle_ready;
  logic       conveyor_moving;
  logic       hopper_empty;
  logic [9:0] hopper_level;
  logic [9:0] pills_in_bottle;
  logic [6:0] bottles_done;
  logic       jammed;

  always #5 clk_1khz = ~clk_1khz;

  bottling_plant_sim #(
    .PILL_PERIOD(P), .MOVE_CYCLES(M), .HOPPER_CAP(CAP), .REFILL_AMOUNT(R)
  ) dut (
    .clk_1khz(clk_1khz), .switch_clr(switch_clr), .fill_en(fill_en),
    .bottle_advance(bottle_advance), .hopper_refill(hopper_refill),
    .fault_hopper(fault_hopper), .fault_jam(fault_jam), .pill_pulse(pill_pulse),
    .bottle_ready(bottle_ready), .conveyor_moving(conveyor_moving),
    .hopper_empty(hopper_empty), .hopper_level(hopper_level),
    .pills_in_bottle(pills_in_bottle), .bottles_done(bottles_done), .jammed(jammed)
  );

  typedef struct packed {
    logic       pulse;
    logic       ready;
    logic       moving;
    logic       jam;
    logic [9:0] level;
    logic [9:0] pills;
    logic [6:0] done;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int checks = 0;
  int errors = 0;

  // Reference model: spec-level quantities (cycles spent filling, cycles of travel).
  int m_mode  = S_IDLE;
  int m_fill_n = 0;
  int m_moved  = 0;
  int m_level  = CAP;
  int m_pills  = 0;
  int m_done   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    int drop;
    bit empty;
    exp_t e;
    drop = 0;
    if (switch_clr) begin
      m_mode = S_IDLE; m_fill_n = 0; m_moved = 0;
      m_level = CAP; m_pills = 0; m_done = 0;
    end else begin
      empty = (m_level == 0) || fault_hopper;
      case (m_mode)
        S_IDLE: begin
          if (bottle_advance) begin m_mode = S_MOVE; m_moved = 0; end
          else if (fill_en && !empty) begin m_mode = S_FILL; m_fill_n = 0; end
        end
        S_FILL: begin
          if (bottle_advance) begin m_mode = S_MOVE; m_moved = 0; end
          else if (!fill_en) m_mode = S_IDLE;
          else begin
            m_fill_n++;
            if ((m_fill_n % P) == 0 && !empty) drop = 1;
          end
        end
        S_MOVE: begin
          if (fault_jam) m_mode = S_JAM;
          else if (m_moved == M - 1) begin
            m_mode = S_IDLE; m_pills = 0; m_done = (m_done + 1) % 100;
          end else m_moved++;
        end
        default: if (!fault_jam) m_mode = S_MOVE;
      endcase
      if (drop == 1) m_pills = (m_pills + 1 > 1023) ? 1023 : m_pills + 1;
      m_level = m_level - drop + (hopper_refill ? R : 0);
      if (m_level > CAP) m_level = CAP;
    end
    e.pulse  = (drop == 1);
    e.ready  = (m_mode == S_IDLE) || (m_mode == S_FILL);
    e.moving = (m_mode == S_MOVE);
    e.jam    = (m_mode == S_JAM);
    e.level  = 10'(m_level);
    e.pills  = 10'(m_pills);
    e.done   = 7'(m_done);
    sb_q.push_back(e);
  endtask

  always @(negedge clk_1khz) begin
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      check("pill_pulse", pill_pulse, mon_e.pulse);
      check("bottle_ready", bottle_ready, mon_e.ready);
      check("conveyor_moving", conveyor_moving, mon_e.moving);
      check("jammed", jammed, mon_e.jam);
      check("hopper_level", hopper_level, mon_e.level);
      check("pills_in_bottle", pills_in_bottle, mon_e.pills);
      check("bottles_done", bottles_done, mon_e.done);
      check("hopper_empty", hopper_empty, (mon_e.level == 10'd0) || fault_hopper);
    end
  end

  task automatic tick();
    @(posedge clk_1khz);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    switch_clr = 1'b1;
    tick();
    switch_clr = 1'b0;
  endtask

  task automatic bottle_cycle();
    bottle_advance = 1'b1;
    tick();
    bottle_advance = 1'b0;
    repeat (M) tick();
  endtask

  initial begin
    int n;
    switch_clr = 1'b1; fill_en = 1'b0; bottle_advance = 1'b0;
    hopper_refill = 1'b0; fault_hopper = 1'b0; fault_jam = 1'b0;
    repeat (3) tick();
    check("rst_ready", bottle_ready, 1);
    check("rst_level", hopper_level, CAP);
    check("rst_pills", pills_in_bottle, 0);
    check("rst_done", bottles_done, 0);
    check("rst_moving", conveyor_moving, 0);
    switch_clr = 1'b0;
    tick();

    // First-pill latency and steady cadence.
    fill_en = 1'b1;
    n = 0;
    while (!pill_pulse && n < 4 * P) begin tick(); n++; end
    check("first_pill_cycles", n - 1, P);
    repeat (2 * P) tick();
    check("fill_pulse3", pill_pulse, 1);
    check("fill_pills", pills_in_bottle, 3);
    check("fill_level", hopper_level, CAP - 3);
    tick();
    check("pulse_one_cycle", pill_pulse, 0);

    // Advance while filling; fill_en is ignored during travel.
    bottle_advance = 1'b1;
    tick();
    bottle_advance = 1'b0;
    check("move_ready", bottle_ready, 0);
    check("move_moving", conveyor_moving, 1);
    repeat (M - 1) tick();
    check("move_still_busy", bottle_ready, 0);
    tick();
    check("arrive_ready", bottle_ready, 1);
    check("arrive_pills", pills_in_bottle, 0);
    check("arrive_done", bottles_done, 1);
    fill_en = 1'b0;
    repeat (2) tick();

    // Jam in the middle of travel freezes the remaining count.
    bottle_advance = 1'b1;
    tick();
    bottle_advance = 1'b0;
    repeat (2) tick();
    fault_jam = 1'b1;
    repeat (6) tick();
    check("jam_flag", jammed, 1);
    check("jam_stopped", conveyor_moving, 0);
    check("jam_ready", bottle_ready, 0);
    fault_jam = 1'b0;
    tick();
    check("unjam_moving", conveyor_moving, 1);
    n = 0;
    while (!bottle_ready && n < 100) begin tick(); n++; end
    check("unjam_remaining", n, M - 2);

    // Drain the hopper, stall, then refill.
    do_reset();
    fill_en = 1'b1;
    n = 0;
    while (!hopper_empty && n < (CAP + 4) * P) begin tick(); n++; end
    check("drain_level", hopper_level, 0);
    check("drain_pills", pills_in_bottle, CAP);
    repeat (3 * P) tick();
    check("empty_no_pills", pills_in_bottle, CAP);
    hopper_refill = 1'b1;
    tick();
    hopper_refill = 1'b0;
    check("refill_level", hopper_level, R);
    n = 0;
    while (!pill_pulse && n < 4 * P) begin tick(); n++; end
    check("pulses_resume", pill_pulse, 1);
    fill_en = 1'b0;

    // Refill at full clamps to capacity.
    do_reset();
    hopper_refill = 1'b1;
    tick();
    hopper_refill = 1'b0;
    check("refill_cap", hopper_level, CAP);

    // Counter wrap and reset in mid-travel.
    repeat (99) bottle_cycle();
    check("done_99", bottles_done, 99);
    bottle_advance = 1'b1;
    tick();
    bottle_advance = 1'b0;
    repeat (M / 2) tick();
    do_reset();
    check("clr_done", bottles_done, 0);
    check("clr_ready", bottle_ready, 1);
    check("clr_moving", conveyor_moving, 0);
    check("clr_level", hopper_level, CAP);
    bottle_cycle();
    check("done_after_clr", bottles_done, 1);
    do_reset();
    repeat (100) bottle_cycle();
    check("done_wrap", bottles_done, 0);

    // Long fill with steady refills drives pills_in_bottle into saturation.
    fill_en = 1'b1;
    for (int i = 0; i < 5300; i++) begin
      hopper_refill = (i % 10 == 0);
      tick();
    end
    hopper_refill = 1'b0;
    check("pills_saturate", pills_in_bottle, 1023);
    fill_en = 1'b0;

    // Randomised traffic against the model.
    for (int i = 0; i < 15000; i++) begin
      if ($urandom_range(0, 19) == 0) fill_en = ~fill_en;
      bottle_advance = ($urandom_range(0, 49) == 0);
      hopper_refill  = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 39) == 0) fault_hopper = ~fault_hopper;
      if ($urandom_range(0, 29) == 0) fault_jam = ~fault_jam;
      switch_clr     = ($urandom_range(0, 1999) == 0);
      tick();
    end
    switch_clr = 1'b0; bottle_advance = 1'b0; hopper_refill = 1'b0;
    tick();
    @(negedge clk_1khz);
    #1;
    check("scoreboard_drained", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bottling_plant_sim.md
BOTTLING_PLANT_SIM -- requirements
Module: bottling_plant_sim

Interface
REQ-001 SHALL have parameter PILL_PERIOD, default 100: clk_1khz cycles between pill drops (10 pills/s); legal range 2..1023.
REQ-002 SHALL have parameter MOVE_CYCLES, default 2000: cycles of conveyor motion per bottle change; legal range 2..4095.
REQ-003 SHALL have parameter HOPPER_CAP, default 999: hopper capacity in pills; legal range 1..1023.
REQ-004 SHALL have parameter REFILL_AMOUNT, default 100: pills added per refill pulse; legal range 1..1023.
REQ-005 SHALL use one clock and a synchronous, active-high reset; no other clock or reset port.
REQ-006 SHALL have port clk_1khz, input, 1 bit: the single clock.
REQ-007 SHALL have port switch_clr, input, 1 bit: synchronous, active-high reset.
REQ-008 SHALL have port fill_en, input, 1 bit: controller requests pills while high.
REQ-009 SHALL have port bottle_advance, input, 1 bit: one-cycle request to move the next bottle in.
REQ-010 SHALL have port hopper_refill, input, 1 bit: one-cycle refill pulse.
REQ-011 SHALL have port fault_hopper, input, 1 bit: forces the hopper to read as empty while high.
REQ-012 SHALL have port fault_jam, input, 1 bit: freezes the conveyor while high.
REQ-013 SHALL have port pill_pulse, output, 1 bit: one-cycle pulse per dispensed pill.
REQ-014 SHALL have port bottle_ready, output, 1 bit: a bottle is in place under the hopper.
REQ-015 SHALL have port conveyor_moving, output, 1 bit: the conveyor is running.
REQ-016 SHALL have port hopper_empty, output, 1 bit: no pill can be dispensed.
REQ-017 SHALL have port hopper_level, output, 10 bits: pills remaining in the hopper.
REQ-018 SHALL have port pills_in_bottle, output, 10 bits: pills in the current bottle.
REQ-019 SHALL have port bottles_done, output, 7 bits: bottles delivered, binary count 0..99.
REQ-020 SHALL have port jammed, output, 1 bit: the conveyor is stopped by a fault.

Function
REQ-021 SHALL implement a state machine with states IDLE, FILLING, MOVING and JAMMED; all outputs SHALL be registered except hopper_empty.
REQ-022 SHALL drive hopper_empty combinationally as (hopper_level == 0) | fault_hopper.
REQ-023 IDLE: bottle_ready=1, conveyor_moving=0; bottle_advance -> MOVING; else fill_en & ~hopper_empty -> FILLING, pill_timer loaded with PILL_PERIOD-1.
REQ-024 bottle_advance SHALL take priority over fill_en in the same cycle.
REQ-025 FILLING: pill_timer decrements each cycle; at 0 with ~hopper_empty -> pill_pulse=1 for exactly one cycle, hopper_level-1, pills_in_bottle+1, timer reloaded with PILL_PERIOD-1.
REQ-026 FILLING with timer at 0 and hopper_empty=1: no pulse, timer reloads, state stays FILLING.
REQ-027 First pill SHALL appear PILL_PERIOD cycles after the fill_en edge that is sampled in IDLE.
REQ-028 FILLING with fill_en=0 -> IDLE next cycle, timer cleared, no pulse that cycle; bottle_advance -> MOVING and cancels any pending pill.
REQ-029 MOVING: bottle_ready=0, conveyor_moving=1, move_timer loaded with MOVE_CYCLES-1 on entry and decrementing.
REQ-030 MOVING at move_timer 0 -> IDLE with bottle_ready=1, pills_in_bottle=0, bottles_done+1 (99 wraps to 0).
REQ-031 MOVING with fault_jam=1 -> JAMMED: jammed=1, conveyor_moving=0, bottle_ready=0, move_timer frozen.
REQ-032 JAMMED with fault_jam=0 -> MOVING, resuming the remaining count without reload.
REQ-033 bottle_advance and fill_en SHALL be ignored in MOVING and JAMMED.
REQ-034 hopper_refill SHALL be honoured in every state: hopper_level = min(HOPPER_CAP, level + REFILL_AMOUNT).
REQ-035 When a refill and a pill drop occur in the same cycle: hopper_level = min(HOPPER_CAP, level - 1 + REFILL_AMOUNT).
REQ-036 pills_in_bottle SHALL saturate at 1023; hopper_level SHALL never underflow.

Reset
REQ-037 switch_clr=1 at a clock edge SHALL give: state IDLE, pill_pulse=0, bottle_ready=1, conveyor_moving=0, jammed=0, hopper_level=HOPPER_CAP, pills_in_bottle=0, bottles_done=0, all timers 0.
REQ-038 Reset SHALL override all inputs, including mid-FILLING or mid-MOVING, with no pulse emitted in the reset cycle.

Verification
REQ-039 Defaults; fill_en=1 for 1000 cycles from IDLE -> 10 pill_pulse, first at cycle 100; pills_in_bottle=10, hopper_level=989.
REQ-040 hopper_level=1; fill_en=1 -> one pulse, hopper_empty=1, no further pulses; hopper_refill -> level 100, pulses resume.
REQ-041 bottle_advance in FILLING -> bottle_ready=0 for 2000 cycles; then bottle_ready=1, pills_in_bottle=0, bottles_done=1.
REQ-042 fault_jam=1 for 500 cycles during MOVING -> jammed=1; bottle_ready returns after 2500 cycles total.
REQ-043 Refill at hopper_level=950 -> 999; refill coinciding with a pill at level 950 -> 999.
REQ-044 switch_clr mid-MOVING with bottles_done=99 -> all reset values next cycle; one full bottle cycle then -> bottles_done=1; separately, 100 bottle cycles from reset -> bottles_done wraps to 0.
